regfile_ctrl: RTL
=================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have parameter NREG, default 8, meaning the number of general-purpose registers.
REQ-002 The block SHALL have parameter W, default 16, meaning the data width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have ports a_valid, input, 1, and a_ready, output, 1: the write request/grant pair for requester A (ALU writeback).
REQ-006 The block SHALL have ports a_dr, input, 3; a_data, input, W; and a_setcc, input, 1: destination register, write data and condition-code update enable for A.
REQ-007 The block SHALL have ports b_valid, b_ready, b_dr, b_data and b_setcc with the same directions and widths as A, for requester B (memory load).
REQ-008 The block SHALL have ports sr1, input, 3, with sr1_data, output, W; and sr2, input, 3, with sr2_data, output, W: two asynchronous read ports.
REQ-009 The block SHALL have port nzp, output, 3, holding the condition codes {N,Z,P}.
REQ-010 The block SHALL have port wr_count, output, 16, counting completed writes.

Function
REQ-011 Storage SHALL be NREG x W flops; at most one register SHALL be written per cycle.
REQ-012 A write transfer SHALL occur on a rising edge where x_valid and x_ready are both 1; the data SHALL be visible on the read ports starting the next cycle.
REQ-013 x_ready SHALL be combinational, 1 only for the granted requester, and 0 when x_valid is 0.
REQ-014 When only one requester is valid, that requester SHALL be granted.
REQ-015 When both are valid, the requester not granted on the most recent transfer SHALL be granted (round-robin); the last-grant flop SHALL update only on a transfer.
REQ-016 A requester SHALL hold valid, dr, data and setcc stable until ready; dropping valid before ready SHALL be legal and SHALL cause no write.
REQ-017 Reads SHALL be combinational from storage with no write bypass; a same-cycle read of the register being written SHALL return the old value.
REQ-018 When both requesters target the same dr in one cycle, only the granted requester SHALL write; the other SHALL retry, so the later write wins.
REQ-019 On a transfer with setcc=1, nzp SHALL load 100 if data[W-1]=1, 010 if data=0, and 001 otherwise; with setcc=0, nzp SHALL be unchanged.
REQ-020 wr_count SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-021 Indices sr1, sr2 or dr of NREG or greater SHALL read 0 and SHALL be ignored for writes; the handshake still completes and wr_count and nzp still update.

Reset
REQ-022 While rst_n=0 at a rising edge, all registers SHALL become 0, nzp SHALL become 010, wr_count SHALL become 0, and last-grant SHALL become B, so A wins the first tie.
REQ-023 While rst_n=0, a_ready and b_ready SHALL be 0 and no write SHALL occur, even mid-handshake.
REQ-024 The first transfer SHALL be possible on the first rising edge after rst_n returns to 1.

Verification
REQ-025 Reset, then a_valid=1, a_dr=3, a_data=0x8001, a_setcc=1 for one cycle -> a_ready=1; next cycle R3=0x8001, nzp=100, wr_count=1.
REQ-026 Both valid for 4 cycles (A: dr=1, B: dr=2) -> grants A,B,A,B; wr_count=4.
REQ-027 Both valid with dr=5 (A data=0x1111, B data=0x2222) for 2 cycles -> R5=0x1111 after cycle 1, then 0x2222; nzp unchanged when setcc=0.
REQ-028 Write dr=4, data=0x0000, setcc=1, with sr1=4 in the same cycle -> sr1_data shows the old value that cycle and 0x0000 the next; nzp=010.
REQ-029 b_valid held high and rst_n=0 in the same cycle -> b_ready=0, no write, all state at reset values.
REQ-030 Preload wr_count to 0xFFFF via 65535 transfers, then one more transfer -> wr_count=0x0000.

Source files
------------

// File: rtl/regfile_ctrl.sv
// Register file with two round-robin arbitrated write requesters and two
// asynchronous read ports; tracks condition codes and a completed-write count.
module regfile_ctrl #(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [2:0]   a_dr,
  input  logic [W-1:0] a_data,
  input  logic         a_setcc,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [2:0]   b_dr,
  input  logic [W-1:0] b_data,
  input  logic         b_setcc,
  input  logic [2:0]   sr1,
  output logic [W-1:0] sr1_data,
  input  logic [2:0]   sr2,
  output logic [W-1:0] sr2_data,
  output logic [2:0]   nzp,
  output logic [15:0]  wr_count
);

  typedef struct packed {
    logic [2:0]   dr;
    logic [W-1:0] data;
    logic         setcc;
  } wreq_t;

  // Which 3-bit indices map onto real storage; the rest read 0 and drop writes.
  function automatic logic [7:0] idx_mask();
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i] = (i < NREG);
    return m;
  endfunction

  localparam logic [7:0] IDX_OK = idx_mask();

  logic [NREG-1:0][W-1:0] regs_q, regs_d;
  logic [2:0]             nzp_q, nzp_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   last_b_q, last_b_d;
  logic                   gnt_a, gnt_b, xfer;
  wreq_t                  wr;

  // On a tie, grant whoever did not win the most recent transfer.
  always_comb begin
    gnt_a = rst_n && a_valid && (!b_valid || last_b_q);
    gnt_b = rst_n && b_valid && (!a_valid || !last_b_q);
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign xfer    = gnt_a | gnt_b;
  assign wr      = gnt_a ? {a_dr, a_data, a_setcc} : {b_dr, b_data, b_setcc};

  always_comb begin
    regs_d   = regs_q;
    nzp_d    = nzp_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    if (xfer) begin
      if (IDX_OK[wr.dr]) regs_d[wr.dr] = wr.data;
      if (wr.setcc) begin
        if (wr.data[W-1])        nzp_d = 3'b100;
        else if (wr.data == '0)  nzp_d = 3'b010;
        else                     nzp_d = 3'b001;
      end
      cnt_d    = cnt_q + 16'd1;
      last_b_d = gnt_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q   <= '0;
      nzp_q    <= 3'b010;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      regs_q   <= regs_d;
      nzp_q    <= nzp_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

  // No write bypass: reads always see the pre-edge contents.
  assign sr1_data = IDX_OK[sr1] ? regs_q[sr1] : '0;
  assign sr2_data = IDX_OK[sr2] ? regs_q[sr2] : '0;
  assign nzp      = nzp_q;
  assign wr_count = cnt_q;

endmodule
